param_register_file: RTL and testbench
======================================

# param_register_file

Parametrised successor to the LC-3b 8x16 register file: WIDTH-bit registers, 2^ADDR_BITS entries, NREAD combinational read ports, one synchronous write port. Adds a per-register scoreboard (busy bits) so the decode stage can reserve a destination at issue and stall readers until writeback. Sits between decode (read/reserve) and writeback (write).

## Interface
- WIDTH, 16: register width in bits.
- ADDR_BITS, 3: address width; DEPTH = 2^ADDR_BITS entries.
- NREAD, 2: number of read ports (1..4).

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all registers and busy bits.
- read_add  input  NREAD*ADDR_BITS  read addresses; port i at bits [i*ADDR_BITS +: ADDR_BITS].
- read_data  output  NREAD*WIDTH  read data, same packing.
- read_ready  output  NREAD  1 = addressed register not busy, data is valid for use.
- write  input  1  active-high write enable.
- write_add  input  ADDR_BITS  write address.
- write_data  input  WIDTH  write data.
- reserve  input  1  active-high: mark reserve_add busy.
- reserve_add  input  ADDR_BITS  register to reserve.
- busy_any  output  1  OR of all busy bits; used for drain/flush.

## Operation
- Storage: DEPTH x WIDTH flops plus DEPTH busy bits. No hardwired-zero register.
- Reset (reset=0, async): all registers 0, all busy 0; read_data reflects 0, read_ready all 1, busy_any 0. Reset asserted mid-write discards the write.
- Write: on rising clk with write=1, reg[write_add] <= write_data and busy[write_add] <= 0.
- Reserve: on rising clk with reserve=1, busy[reserve_add] <= 1.
- Same edge, reserve_add == write_add: reserve wins (busy stays/becomes 1, new producer outstanding); data is still written.
- Reserve of an already-busy register: stays busy (no counting; one outstanding producer per register is the decode stage's rule).
- Write to a non-busy register: legal, writes data, busy stays 0.
- Read: read_data[i] = reg[read_add[i]] combinationally; read_ready[i] = ~busy[read_add[i]]. Multiple ports may address the same register.
- Address arithmetic: addresses are used unsigned, exactly ADDR_BITS wide; no out-of-range case exists.

## Timing
- Read latency 0 cycles (combinational from read_add and state).
- Write visible on read_data the cycle after the write edge (without bypass).
- Reserve visible on read_ready the cycle after the reserve edge; release visible the cycle after the write edge (without bypass).
- No handshake on write port; writeback must not issue write unless the result is final.

## Configuration
- REGFILE_BYPASS_EN defined: if write=1 and write_add == read_add[i] in the same cycle, read_data[i] = write_data and read_ready[i] = 1 combinationally (unless reserve=1 to the same address that cycle, then read_ready[i] = 0, data still bypassed).
- Undefined: no forwarding; read_data/read_ready reflect stored state only, one cycle later.

## Structure
- Shared package rf_pkg: default WIDTH/ADDR_BITS/NREAD constants, LC-3b register-number constants (R0..R7).
- Sub-module rf_entry: one register plus its busy bit, with write/reserve enables and async active-low reset; instantiated DEPTH times via generate. Read muxing and bypass logic in the top.

## Test plan
- Reset: drive reset=0 with random inputs -> all read_data 0, read_ready all 1, busy_any 0; release and read R0..R7 -> 0.
- Fill and read back: write 455->R6, 4817->R2, 18431->R0, 848->R3, 4->R5, 8463->R7, 23584->R1, 42->R4; read ports (5,7) -> 4, 8463; (2,0) -> 4817, 18431.
- Scoreboard: reserve R3 -> next cycle read_ready for R3 = 0, busy_any = 1; write 99->R3 -> next cycle ready=1, data 99, busy_any 0.
- Collision: same edge reserve R2 and write 7->R2 -> R2 reads 7, read_ready 0.
- Bypass (REGFILE_BYPASS_EN): write 1234->R5 while read_add[0]=5 -> read_data 1234, ready 1 in the same cycle; without macro -> old value 4 that cycle, 1234 next.
- Mid-operation reset: write 555->R1 with reset pulsed low before edge -> R1 reads 0, all busy cleared.

Source files
------------

// File: rtl/param_register_file_pkg.sv
// Shared constants for the parametrised register file: default geometry and
// the LC-3b register numbers.
package rf_pkg;
   localparam int RF_WIDTH     = 16;
   localparam int RF_ADDR_BITS = 3;
   localparam int RF_NREAD     = 2;

   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;
endpackage

// File: rtl/param_register_file_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write port,
// reserve port and the drain indicator.
interface param_register_file_if
   import rf_pkg::*;
#(
   parameter int WIDTH     = RF_WIDTH,
   parameter int ADDR_BITS = RF_ADDR_BITS,
   parameter int NREAD     = RF_NREAD
);
   logic [NREAD*ADDR_BITS-1:0] read_add;
   logic [NREAD*WIDTH-1:0]     read_data;
   logic [NREAD-1:0]           read_ready;
   logic                       write;
   logic [ADDR_BITS-1:0]       write_add;
   logic [WIDTH-1:0]           write_data;
   logic                       reserve;
   logic [ADDR_BITS-1:0]       reserve_add;
   logic                       busy_any;

   modport master (
      output read_add, write, write_add, write_data, reserve, reserve_add,
      input  read_data, read_ready, busy_any
   );

   modport slave (
      input  read_add, write, write_add, write_data, reserve, reserve_add,
      output read_data, read_ready, busy_any
   );
endinterface

// File: rtl/param_register_file_entry.sv
// One register plus its scoreboard busy bit. A reserve on the same edge as a
// write wins the busy bit: the new producer is still outstanding.
module rf_entry #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rsv_en,
   output logic [WIDTH-1:0] q,
   output logic             busy
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         busy <= 1'b0;
      end else begin
         if (wr_en) q <= wr_data;
         if (rsv_en)     busy <= 1'b1;
         else if (wr_en) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module param_register_file
   import rf_pkg::*;
#(
   parameter int WIDTH     = RF_WIDTH,
   parameter int ADDR_BITS = RF_ADDR_BITS,
   parameter int NREAD     = RF_NREAD
) (
   input  logic                  clk,
   input  logic                  reset,
   param_register_file_if.slave  rf
);
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DEPTH-1:0][WIDTH-1:0] regs;
   logic [DEPTH-1:0]            busy;
   logic [DEPTH-1:0]            wr_en;
   logic [DEPTH-1:0]            rsv_en;
   logic [NREAD-1:0][WIDTH-1:0] rdata;
   logic [NREAD-1:0]            rdy;
   logic [ADDR_BITS-1:0]        ra;

   always_comb begin
      wr_en  = '0;
      rsv_en = '0;
      if (rf.write)   wr_en[rf.write_add]    = 1'b1;
      if (rf.reserve) rsv_en[rf.reserve_add] = 1'b1;
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      rf_entry #(.WIDTH(WIDTH)) u_entry (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[e]),
         .wr_data (rf.write_data),
         .rsv_en  (rsv_en[e]),
         .q       (regs[e]),
         .busy    (busy[e])
      );
   end

   always_comb begin
      rdata = '0;
      rdy   = '0;
      ra    = '0;
      for (int i = 0; i < NREAD; i++) begin
         ra       = rf.read_add[i*ADDR_BITS +: ADDR_BITS];
         rdata[i] = regs[ra];
         rdy[i]   = ~busy[ra];
`ifdef REGFILE_BYPASS_EN
         // Forwarding is suppressed during reset so outputs show the cleared state.
         if (reset && rf.write && (rf.write_add == ra)) begin
            rdata[i] = rf.write_data;
            rdy[i]   = !(rf.reserve && (rf.reserve_add == ra));
         end
`endif
      end
   end

   assign rf.read_data  = rdata;
   assign rf.read_ready = rdy;
   assign rf.busy_any   = |busy;
endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file (default 16x8, 2 read ports).
module tb_param_register_file;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   param_register_file_if #(.WIDTH(16), .ADDR_BITS(3), .NREAD(2)) rf_bus ();

   param_register_file #(.WIDTH(16), .ADDR_BITS(3), .NREAD(2)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf_bus.write       = 1'b0;
      rf_bus.reserve     = 1'b0;
      rf_bus.write_add   = '0;
      rf_bus.reserve_add = '0;
      rf_bus.write_data  = '0;
   endtask

   task automatic test_reset();
      logic [2:0] a0, a1;
      reset              = 1'b0;
      rf_bus.write       = 1'b1;
      rf_bus.reserve     = 1'b1;
      rf_bus.write_add   = 3'($urandom_range(0, 7));
      rf_bus.reserve_add = 3'($urandom_range(0, 7));
      rf_bus.write_data  = 16'($urandom);
      rf_bus.read_add    = 6'($urandom);
      step();
      checks++;
      if (rf_bus.read_data !== 32'h0) begin
         errors++; $display("FAIL reset_data got=%h want=0", rf_bus.read_data);
      end
      checks++;
      if (rf_bus.read_ready !== 2'b11) begin
         errors++; $display("FAIL reset_ready got=%b want=11", rf_bus.read_ready);
      end
      checks++;
      if (rf_bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL reset_busy_any got=%b want=0", rf_bus.busy_any);
      end
      idle();
      reset = 1'b1;
      step();
      for (int r = 0; r < 8; r += 2) begin
         a0 = 3'(r); a1 = 3'(r + 1);
         rf_bus.read_add = {a1, a0};
         #1;
         checks++;
         if (rf_bus.read_data !== 32'h0) begin
            errors++; $display("FAIL reset_readback R%0d/R%0d got=%h want=0", r, r + 1, rf_bus.read_data);
         end
      end
   endtask

   task automatic test_fill();
      logic [2:0]  fa [8] = '{R6, R2, R0, R3, R5, R7, R1, R4};
      logic [15:0] fv [8] = '{16'd455, 16'd4817, 16'd18431, 16'd848,
                              16'd4, 16'd8463, 16'd23584, 16'd42};
      for (int k = 0; k < 8; k++) begin
         rf_bus.write      = 1'b1;
         rf_bus.write_add  = fa[k];
         rf_bus.write_data = fv[k];
         step();
      end
      idle();
      rf_bus.read_add = {R7, R5};
      #1;
      checks++;
      if (rf_bus.read_data !== {16'd8463, 16'd4}) begin
         errors++; $display("FAIL fill_r5_r7 got=%h want=%h", rf_bus.read_data, {16'd8463, 16'd4});
      end
      rf_bus.read_add = {R0, R2};
      #1;
      checks++;
      if (rf_bus.read_data !== {16'd18431, 16'd4817}) begin
         errors++; $display("FAIL fill_r2_r0 got=%h want=%h", rf_bus.read_data, {16'd18431, 16'd4817});
      end
      rf_bus.read_add = {R4, R6};
      #1;
      checks++;
      if (rf_bus.read_data !== {16'd42, 16'd455}) begin
         errors++; $display("FAIL fill_r6_r4 got=%h want=%h", rf_bus.read_data, {16'd42, 16'd455});
      end
      rf_bus.read_add = {R3, R1};
      #1;
      checks++;
      if (rf_bus.read_data !== {16'd848, 16'd23584}) begin
         errors++; $display("FAIL fill_r1_r3 got=%h want=%h", rf_bus.read_data, {16'd848, 16'd23584});
      end
      checks++;
      if (rf_bus.read_ready !== 2'b11 || rf_bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL fill_ready got=%b/%b want=11/0", rf_bus.read_ready, rf_bus.busy_any);
      end
   endtask

   task automatic test_scoreboard();
      rf_bus.reserve     = 1'b1;
      rf_bus.reserve_add = R3;
      rf_bus.read_add    = {R3, R3};
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b11) begin
         errors++; $display("FAIL sb_before_edge got=%b want=11", rf_bus.read_ready);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b00 || rf_bus.busy_any !== 1'b1) begin
         errors++; $display("FAIL sb_reserved got=%b/%b want=00/1", rf_bus.read_ready, rf_bus.busy_any);
      end
      checks++;
      if (rf_bus.read_data !== {16'd848, 16'd848}) begin
         errors++; $display("FAIL sb_old_data got=%h want=%h", rf_bus.read_data, {16'd848, 16'd848});
      end
      rf_bus.read_add = {R4, R3};
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b10) begin
         errors++; $display("FAIL sb_other_port got=%b want=10", rf_bus.read_ready);
      end
      rf_bus.write      = 1'b1;
      rf_bus.write_add  = R3;
      rf_bus.write_data = 16'd99;
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b11 || rf_bus.busy_any !== 1'b0 || rf_bus.read_data[15:0] !== 16'd99) begin
         errors++; $display("FAIL sb_release got=%b/%b/%0d want=11/0/99",
                            rf_bus.read_ready, rf_bus.busy_any, rf_bus.read_data[15:0]);
      end
      // double reserve is not counted: one write releases
      rf_bus.reserve = 1'b1; rf_bus.reserve_add = R4;
      step();
      step();
      idle();
      rf_bus.read_add = {R4, R4};
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b00) begin
         errors++; $display("FAIL sb_double_reserve got=%b want=00", rf_bus.read_ready);
      end
      rf_bus.write = 1'b1; rf_bus.write_add = R4; rf_bus.write_data = 16'd43;
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.read_ready !== 2'b11 || rf_bus.busy_any !== 1'b0 || rf_bus.read_data[15:0] !== 16'd43) begin
         errors++; $display("FAIL sb_double_release got=%b/%b/%0d want=11/0/43",
                            rf_bus.read_ready, rf_bus.busy_any, rf_bus.read_data[15:0]);
      end
   endtask

   task automatic test_collision();
      rf_bus.reserve     = 1'b1;
      rf_bus.reserve_add = R2;
      rf_bus.write       = 1'b1;
      rf_bus.write_add   = R2;
      rf_bus.write_data  = 16'd7;
      step();
      idle();
      rf_bus.read_add = {R0, R2};
      #1;
      checks++;
      if (rf_bus.read_data[15:0] !== 16'd7 || rf_bus.read_ready !== 2'b10 || rf_bus.busy_any !== 1'b1) begin
         errors++; $display("FAIL collision got=%0d/%b/%b want=7/10/1",
                            rf_bus.read_data[15:0], rf_bus.read_ready, rf_bus.busy_any);
      end
      rf_bus.write = 1'b1; rf_bus.write_add = R2; rf_bus.write_data = 16'd8;
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.read_data[15:0] !== 16'd8 || rf_bus.read_ready !== 2'b11 || rf_bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL collision_release got=%0d/%b/%b want=8/11/0",
                            rf_bus.read_data[15:0], rf_bus.read_ready, rf_bus.busy_any);
      end
   endtask

   task automatic test_bypass();
      logic [15:0] exp_d;
      rf_bus.read_add   = {R7, R5};
      rf_bus.write      = 1'b1;
      rf_bus.write_add  = R5;
      rf_bus.write_data = 16'd1234;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_d = 16'd1234;
`else
      exp_d = 16'd4;
`endif
      checks++;
      if (rf_bus.read_data[15:0] !== exp_d || rf_bus.read_ready[0] !== 1'b1) begin
         errors++; $display("FAIL bypass_same_cycle got=%0d/%b want=%0d/1",
                            rf_bus.read_data[15:0], rf_bus.read_ready[0], exp_d);
      end
      checks++;
      if (rf_bus.read_data[31:16] !== 16'd8463) begin
         errors++; $display("FAIL bypass_other_port got=%0d want=8463", rf_bus.read_data[31:16]);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.read_data[15:0] !== 16'd1234) begin
         errors++; $display("FAIL bypass_next_cycle got=%0d want=1234", rf_bus.read_data[15:0]);
      end
   endtask

   task automatic test_mid_reset();
      rf_bus.reserve = 1'b1; rf_bus.reserve_add = R6;
      step();
      idle();
      #1;
      checks++;
      if (rf_bus.busy_any !== 1'b1) begin
         errors++; $display("FAIL midrst_pre_busy got=%b want=1", rf_bus.busy_any);
      end
      rf_bus.write      = 1'b1;
      rf_bus.write_add  = R1;
      rf_bus.write_data = 16'd555;
      #1;
      reset = 1'b0;
      step();
      idle();
      reset = 1'b1;
      rf_bus.read_add = {R6, R1};
      #1;
      checks++;
      if (rf_bus.read_data !== 32'h0 || rf_bus.read_ready !== 2'b11 || rf_bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL midrst_cleared got=%h/%b/%b want=0/11/0",
                            rf_bus.read_data, rf_bus.read_ready, rf_bus.busy_any);
      end
      rf_bus.read_add = {R7, R5};
      #1;
      checks++;
      if (rf_bus.read_data !== 32'h0) begin
         errors++; $display("FAIL midrst_others got=%h want=0", rf_bus.read_data);
      end
   endtask

   initial begin
      idle();
      rf_bus.read_add = '0;
      test_reset();
      test_fill();
      test_scoreboard();
      test_collision();
      test_bypass();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
